// File: rtl/serializer.sv
// -----------------------------------------------------------------------------
// serializer
//
// Transmit-side partner of the serial deserializer. A parallel word is taken
// over a valid/ready handshake. When HAS_ECC is set, Hamming check bits are
// appended to it. The resulting frame is then shifted out MSB-first on one
// serial line. Each bit is held for CLKS_PER_BIT clocks, and an enable strobe
// marks the first clock of every bit period. A start marker accompanies the
// strobe of frame bit 0.
//
// Ports
//   clk_i     : clock, all logic on the rising edge
//   rst_i     : synchronous, active-high reset
//   data_i    : parallel payload (DATA_WIDTH bits)
//   valid_i   : data_i is valid
//   ready_o   : block can accept a word (combinational: idle and not in reset)
//   serial_o  : serial data, frame MSB first (registered)
//   start_o   : high on the strobe cycle of frame bit 0 only (registered)
//   enable_o  : one-cycle strobe at the first clock of each bit period (registered)
//   busy_o    : frame in progress (registered)
//   done_o    : one-cycle pulse on the clock after the final bit period (registered)
//
// Check-bit layout (HAS_ECC=1): the codeword positions are numbered 1..CODED_WIDTH.
// Position 2**i holds check bit i. Data bits fill the remaining positions in
// ascending order, with data bit 0 at position 3. Check bit i is the XOR of the
// data bits whose position has bit i set. The frame is {data, check[PAR_WIDTH-1:0]}.
// This is the order the receiver's pad input expects.
// -----------------------------------------------------------------------------
module serializer #(
    parameter int DATA_WIDTH   = 8,
    parameter int HAS_ECC      = 0,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic                  serial_o,
    output logic                  start_o,
    output logic                  enable_o,
    output logic                  busy_o,
    output logic                  done_o
);

    // Smallest r with 2**r >= dw + r + 1 (single-error-correcting Hamming).
    function automatic int calc_parity_width(input int dw);
        int r;
        r = 0;
        for (int k = 30; k >= 1; k--) begin
            if ((1 << k) >= (dw + k + 1)) begin
                r = k;
            end
        end
        return r;
    endfunction

    localparam int PAR_WIDTH   = calc_parity_width(DATA_WIDTH);
    localparam int CODED_WIDTH = DATA_WIDTH + PAR_WIDTH;
    localparam int FRAME_WIDTH = (HAS_ECC != 0) ? CODED_WIDTH : DATA_WIDTH;
    localparam int BIT_CNT_W   = $clog2(FRAME_WIDTH) + 1;
    localparam int PHASE_W     = $clog2(CLKS_PER_BIT) + 1;

    localparam logic [BIT_CNT_W-1:0] LAST_BIT   = BIT_CNT_W'(FRAME_WIDTH - 1);
    localparam logic [PHASE_W-1:0]   LAST_PHASE = PHASE_W'(CLKS_PER_BIT - 1);

    // Hamming check bits for a payload word. See the header for the bit layout.
    function automatic logic [PAR_WIDTH-1:0] hamming_parity(input logic [DATA_WIDTH-1:0] d);
        logic [PAR_WIDTH-1:0] p;
        int                   di;
        p  = '0;
        di = 0;
        for (int pos = 1; pos <= CODED_WIDTH; pos++) begin
            // Power-of-two positions hold check bits. Every other position holds the next data bit.
            if ((pos & (pos - 1)) != 0) begin
                for (int i = 0; i < PAR_WIDTH; i++) begin
                    if (pos[i]) begin
                        p[i] = p[i] ^ d[di];
                    end
                end
                di = di + 1;
            end
        end
        return p;
    endfunction

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t                 state_r;
    logic [FRAME_WIDTH-1:0] shift_r;
    logic [BIT_CNT_W-1:0]   bit_cnt_r;
    logic [PHASE_W-1:0]     phase_r;
    logic                   serial_r;
    logic                   start_r;
    logic                   enable_r;
    logic                   busy_r;
    logic                   done_r;

    logic [FRAME_WIDTH-1:0] frame_s;
    logic                   ready_s;
    logic                   accept_s;
    logic                   phase_wrap_s;
    logic                   last_bit_s;

    generate
        if (HAS_ECC != 0) begin : g_ecc
            // Frame = payload followed by its check bits, both taken from data_i in the same cycle.
            always_comb begin
                frame_s = {data_i, hamming_parity(data_i)};
            end
        end else begin : g_plain
            // Frame is the bare payload.
            always_comb begin
                frame_s = data_i;
            end
        end
    endgenerate

    // Handshake and counter terminal decodes.
    always_comb begin
        ready_s      = (state_r == ST_IDLE) && !rst_i;
        accept_s     = valid_i && ready_s;
        phase_wrap_s = (phase_r == LAST_PHASE);
        last_bit_s   = (bit_cnt_r == LAST_BIT);
    end

    // Frame FSM. The outputs are registered with the values of the coming
    // cycle, so bit k appears on the clock after the counters have advanced to it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r   <= ST_IDLE;
            shift_r   <= '0;
            bit_cnt_r <= '0;
            phase_r   <= '0;
            serial_r  <= 1'b0;
            start_r   <= 1'b0;
            enable_r  <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (accept_s) begin
                        state_r   <= ST_SEND;
                        shift_r   <= frame_s;
                        bit_cnt_r <= '0;
                        phase_r   <= '0;
                        serial_r  <= frame_s[FRAME_WIDTH-1];
                        start_r   <= 1'b1;
                        enable_r  <= 1'b1;
                        busy_r    <= 1'b1;
                    end else begin
                        serial_r  <= 1'b0;
                        start_r   <= 1'b0;
                        enable_r  <= 1'b0;
                        busy_r    <= 1'b0;
                    end
                end
                ST_SEND: begin
                    start_r <= 1'b0;
                    if (phase_wrap_s) begin
                        phase_r <= '0;
                        if (last_bit_s) begin
                            // Final bit period ends: release the line and flag completion.
                            state_r   <= ST_IDLE;
                            bit_cnt_r <= '0;
                            serial_r  <= 1'b0;
                            enable_r  <= 1'b0;
                            busy_r    <= 1'b0;
                            done_r    <= 1'b1;
                        end else begin
                            // Next bit: the one below the current MSB becomes the new MSB.
                            shift_r   <= {shift_r[FRAME_WIDTH-2:0], 1'b0};
                            bit_cnt_r <= bit_cnt_r + BIT_CNT_W'(1);
                            serial_r  <= shift_r[FRAME_WIDTH-2];
                            enable_r  <= 1'b1;
                            busy_r    <= 1'b1;
                            done_r    <= 1'b0;
                        end
                    end else begin
                        phase_r  <= phase_r + PHASE_W'(1);
                        enable_r <= 1'b0;
                        busy_r   <= 1'b1;
                        done_r   <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    shift_r   <= '0;
                    bit_cnt_r <= '0;
                    phase_r   <= '0;
                    serial_r  <= 1'b0;
                    start_r   <= 1'b0;
                    enable_r  <= 1'b0;
                    busy_r    <= 1'b0;
                    done_r    <= 1'b0;
                end
            endcase
        end
    end

    assign ready_o  = ready_s;
    assign serial_o = serial_r;
    assign start_o  = start_r;
    assign enable_o = enable_r;
    assign busy_o   = busy_r;
    assign done_o   = done_r;

endmodule

// File: tb/tb_serializer.sv
// -----------------------------------------------------------------------------
// tb_serializer
//
// Two serializer instances share a clock:
//   u0 : DATA_WIDTH=8, HAS_ECC=0, CLKS_PER_BIT=1
//   u1 : DATA_WIDTH=8, HAS_ECC=1, CLKS_PER_BIT=4 (12-bit frames)
// A behavioural receiver per instance reassembles frames from enable/start/serial.
// Expected results are queued when a word is sent, and they are compared when
// the receiver completes a frame. Receiver 1 can invert one chosen bit position
// and then runs a Hamming syndrome decode on the frame.
// -----------------------------------------------------------------------------
module tb_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0, valid0, ready0, serial0, start0, enable0, busy0, done0;
    logic       rst1, valid1, ready1, serial1, start1, enable1, busy1, done1;
    logic [7:0] data0, data1;

    serializer #(.DATA_WIDTH(8), .HAS_ECC(0), .CLKS_PER_BIT(1)) u0 (
        .clk_i(clk), .rst_i(rst0), .data_i(data0), .valid_i(valid0), .ready_o(ready0),
        .serial_o(serial0), .start_o(start0), .enable_o(enable0), .busy_o(busy0), .done_o(done0));

    serializer #(.DATA_WIDTH(8), .HAS_ECC(1), .CLKS_PER_BIT(4)) u1 (
        .clk_i(clk), .rst_i(rst1), .data_i(data1), .valid_i(valid1), .ready_o(ready1),
        .serial_o(serial1), .start_o(start1), .enable_o(enable1), .busy_o(busy1), .done_o(done1));

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [11:0] frame;
        logic [7:0]  data;
        int          errs;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   rx_cnt0 = 0;
    int   rx_cnt1 = 0;
    int   pushed0 = 0;
    int   pushed1 = 0;

    // Model encoder: the check bits equal the XOR of the positions of the set data bits.
    function automatic logic [11:0] enc(input logic [7:0] d);
        int s;
        int j;
        s = 0;
        j = 0;
        for (int pos = 1; pos <= 12; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                if (d[j]) s = s ^ pos;
                j++;
            end
        end
        return {d, s[3:0]};
    endfunction

    // Syndrome decoder: frame {d[7:0], p[3:0]} -> corrected data and error count.
    task automatic decode(input logic [11:0] f, output logic [7:0] d, output int errs);
        logic [12:0] code;
        int          j;
        int          pi;
        int          syn;
        code = '0;
        j    = 0;
        pi   = 0;
        for (int pos = 1; pos <= 12; pos++) begin
            if ((pos & (pos - 1)) == 0) begin
                code[pos] = f[pi];
                pi++;
            end else begin
                code[pos] = f[4 + j];
                j++;
            end
        end
        syn = 0;
        for (int pos = 1; pos <= 12; pos++) begin
            if (code[pos]) syn = syn ^ pos;
        end
        errs = 0;
        if (syn != 0 && syn <= 12) begin
            code[syn] = ~code[syn];
            errs      = 1;
        end else if (syn > 12) begin
            errs = 2;
        end
        j = 0;
        d = '0;
        for (int pos = 1; pos <= 12; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                d[j] = code[pos];
                j++;
            end
        end
    endtask

    // ---------------- receiver 0 (plain, 8 bits) ----------------
    logic [7:0] sh0;
    int         n0;
    logic       rx_done0 = 1'b0;

    always @(negedge clk) begin
        rx_done0 <= 1'b0;
        if (enable0) begin
            if (start0) begin
                sh0 <= {7'b0, serial0};
                n0  <= 1;
            end else begin
                sh0      <= {sh0[6:0], serial0};
                n0       <= n0 + 1;
                rx_done0 <= (n0 + 1 == 8);
            end
        end
    end

    task automatic rx0_check();
        exp_t e;
        rx_cnt0++;
        if (q0.size() == 0) begin
            check("rx0_unexpected_frame", 32'(sh0), 32'hFFFF_FFFF);
        end else begin
            e = q0.pop_front();
            check("rx0_data", 32'(sh0), 32'(e.data));
        end
    endtask

    always @(negedge clk) if (rx_done0) rx0_check();

    // ---------------- receiver 1 (ECC, 12 bits, optional bit flip) ----------------
    logic [11:0] sh1;
    int          n1;
    logic        rx_done1 = 1'b0;
    int          flip1    = -1;
    logic [11:0] last_raw1 = '0;

    always @(negedge clk) begin
        rx_done1 <= 1'b0;
        if (enable1) begin
            if (start1) begin
                sh1 <= {11'b0, serial1 ^ (flip1 == 0)};
                n1  <= 1;
            end else begin
                sh1      <= {sh1[10:0], serial1 ^ (flip1 == n1)};
                n1       <= n1 + 1;
                rx_done1 <= (n1 + 1 == 12);
            end
        end
    end

    task automatic rx1_check();
        exp_t       e;
        logic [7:0] d;
        int         errs;
        rx_cnt1++;
        last_raw1 = sh1;
        decode(sh1, d, errs);
        if (q1.size() == 0) begin
            check("rx1_unexpected_frame", 32'(sh1), 32'hFFFF_FFFF);
        end else begin
            e = q1.pop_front();
            check("rx1_raw_frame", 32'(sh1), 32'(e.frame));
            check("rx1_corrected_data", 32'(d), 32'(e.data));
            check("rx1_num_errors", 32'(errs), 32'(e.errs));
        end
    endtask

    always @(negedge clk) if (rx_done1) rx1_check();

    // ---------------- helpers ----------------
    task automatic push(input int sel, input logic [7:0] d, input int flip, input logic [7:0] exp_d,
                        input int exp_errs);
        exp_t        e;
        logic [11:0] mask;
        mask = (flip >= 0) ? (12'h800 >> flip) : 12'h000;
        e.data = exp_d;
        e.errs = exp_errs;
        if (sel == 0) begin
            e.frame = {4'h0, d};
            q0.push_back(e);
            pushed0++;
        end else begin
            e.frame = enc(d) ^ mask;
            q1.push_back(e);
            pushed1++;
        end
    endtask

    task automatic send(input int sel, input logic [7:0] d);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if ((sel == 0) ? ready0 : ready1) begin
                ok = 1'b1;
                break;
            end
        end
        check("send_ready_timeout", 32'(ok), 32'd1);
        if (ok) begin
            if (sel == 0) begin data0 = d; valid0 = 1'b1; end
            else          begin data1 = d; valid1 = 1'b1; end
            @(posedge clk);
            @(negedge clk);
            valid0 = 1'b0;
            valid1 = 1'b0;
        end
    endtask

    task automatic wait_done(input int sel);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if ((sel == 0) ? done0 : done1) begin
                ok = 1'b1;
                break;
            end
        end
        check("done_timeout", 32'(ok), 32'd1);
    endtask

    typedef struct {
        int         sel;
        logic [7:0] data;
        int         flip;
        logic [7:0] exp_data;
        int         exp_errs;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [7:0]  w;
        logic [11:0] f;
        int          cnt_before;

        vecs[0] = '{0, 8'h5A, -1, 8'h5A, 0};
        vecs[1] = '{0, 8'hFF, -1, 8'hFF, 0};
        vecs[2] = '{0, 8'h00, -1, 8'h00, 0};
        vecs[3] = '{1, 8'hC3,  5, 8'hC3, 1};
        vecs[4] = '{1, 8'h96,  0, 8'h96, 1};
        vecs[5] = '{1, 8'h01, 11, 8'h01, 1};
        vecs[6] = '{1, 8'h7E, -1, 8'h7E, 0};
        vecs[7] = '{0, 8'h81, -1, 8'h81, 0};

        rst0 = 1'b1; rst1 = 1'b1;
        valid0 = 1'b0; valid1 = 1'b0;
        data0 = 8'h00; data1 = 8'h00;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready_in_reset", 32'(ready0), 32'd0);
        check("rst_outputs0", 32'({serial0, start0, enable0, busy0, done0}), 32'd0);
        check("rst_outputs1", 32'({serial1, start1, enable1, busy1, done1}), 32'd0);
        rst0 = 1'b0; rst1 = 1'b0;
        #1;
        check("rst_ready0", 32'(ready0), 32'd1);
        check("rst_ready1", 32'(ready1), 32'd1);

        // Test 1: 8'hA5, cycle-exact bit sequence
        w = 8'hA5;
        @(negedge clk);
        data0 = w; valid0 = 1'b1;
        push(0, w, -1, w, 0);
        @(posedge clk);
        @(negedge clk);
        valid0 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check("t1_enable", 32'(enable0), 32'd1);
            check("t1_serial", 32'(serial0), 32'(w[7 - k]));
            check("t1_start", 32'(start0), 32'(k == 0));
            check("t1_busy_ready", 32'({busy0, ready0, done0}), 32'b100);
            @(negedge clk);
        end
        check("t1_done_cycle", 32'({done0, ready0, enable0, serial0, busy0}), 32'b11000);
        @(negedge clk);
        check("t1_done_pulse_once", 32'(done0), 32'd0);

        // Test 2 + 6: CLKS_PER_BIT=4 ECC frame of 8'h3C, inputs disturbed mid-frame
        w = 8'h3C;
        f = enc(w);
        @(negedge clk);
        data1 = w; valid1 = 1'b1;
        push(1, w, -1, w, 0);
        @(posedge clk);
        for (int c = 0; c < 48; c++) begin
            @(negedge clk);
            check("t2_enable", 32'(enable1), 32'((c % 4) == 0));
            check("t2_start", 32'(start1), 32'(c == 0));
            check("t2_serial", 32'(serial1), 32'(f[11 - (c / 4)]));
            check("t2_ready_busy", 32'({ready1, busy1}), 32'b01);
            valid1 = c[0];
            data1  = 8'($urandom);
        end
        valid1 = 1'b0;
        @(negedge clk);
        check("t2_done_cycle", 32'({done1, ready1, enable1, busy1}), 32'b1100);

        // Test 3: back-to-back with valid held high
        @(negedge clk);
        data0 = 8'h01; valid0 = 1'b1;
        push(0, 8'h01, -1, 8'h01, 0);
        push(0, 8'h80, -1, 8'h80, 0);
        @(posedge clk);
        @(negedge clk);
        data0 = 8'h80;
        for (int k = 0; k < 8; k++) begin
            check("t3_enable_first", 32'(enable0), 32'd1);
            @(negedge clk);
        end
        check("t3_gap_cycle", 32'({enable0, done0, ready0}), 32'b011);
        @(posedge clk);
        @(negedge clk);
        check("t3_second_start", 32'({start0, enable0, busy0}), 32'b111);
        valid0 = 1'b0;
        wait_done(0);

        // Test 4: ECC frame of 8'hC3, raw frame against its hand-computed code
        flip1 = -1;
        push(1, 8'hC3, -1, 8'hC3, 0);
        send(1, 8'hC3);
        wait_done(1);
        @(negedge clk);
        check("t4_c3_raw_frame", 32'(last_raw1), 32'h0000_0C31);

        // Test 5: reset during bit 4
        cnt_before = rx_cnt0;
        @(negedge clk);
        data0 = 8'hF0; valid0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid0 = 1'b0;
        repeat (4) @(negedge clk);
        check("t5_mid_frame_busy", 32'(busy0), 32'd1);
        rst0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t5_outputs_cleared", 32'({serial0, start0, enable0, busy0, done0}), 32'd0);
        rst0 = 1'b0;
        #1;
        check("t5_ready_after_reset", 32'(ready0), 32'd1);
        repeat (10) @(negedge clk);
        check("t5_no_done_no_strobe", 32'({done0, enable0}), 32'd0);
        check("t5_no_rx_frame", 32'(rx_cnt0), 32'(cnt_before));

        // Table-driven vectors (includes 8'h5A after the aborted frame)
        foreach (vecs[i]) begin
            if (vecs[i].sel == 1) flip1 = vecs[i].flip;
            push(vecs[i].sel, vecs[i].data, vecs[i].flip, vecs[i].exp_data, vecs[i].exp_errs);
            send(vecs[i].sel, vecs[i].data);
            wait_done(vecs[i].sel);
            @(negedge clk);
            flip1 = -1;
        end

        repeat (4) @(negedge clk);
        check("final_q0_empty", 32'(q0.size()), 32'd0);
        check("final_q1_empty", 32'(q1.size()), 32'd0);
        check("final_rx_cnt0", 32'(rx_cnt0), 32'(pushed0));
        check("final_rx_cnt1", 32'(rx_cnt1), 32'(pushed1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
